// File: rtl/compressed_frame_parser_pkg.sv
// +------------------------------------------------------------------+
// | compressed_frame_parser_pkg: shared widths and header layout     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package compressed_frame_parser_pkg;
  localparam int AXI_DATA_BITS   = 512;
  localparam int KEEP_W          = AXI_DATA_BITS / 8;
  localparam int TID_W           = 6;
  localparam int PAGE_SIZE       = 4096;
  localparam int PAGE_SIZE_WIDTH = 16;
  localparam int HEADER_SIZE     = 32;

  typedef logic [PAGE_SIZE_WIDTH-1:0] page_size_t;

  // Packed MSB-first, so com_size lands in the low half of the header beat.
  typedef struct packed {
    page_size_t uncom_size;
    page_size_t com_size;
  } frame_hdr_t;
endpackage

`default_nettype wire

// File: rtl/compressed_frame_parser_byte_counter.sv
// +------------------------------------------------------------------+
// | frame_byte_counter: tkeep popcount with saturating accumulator   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module frame_byte_counter
  import compressed_frame_parser_pkg::*;
#(
  parameter int KEEP_BITS = KEEP_W,
  parameter int CNT_W     = PAGE_SIZE_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic [KEEP_BITS-1:0] keep_i,
  output logic [CNT_W-1:0]     final_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   w_sum;

  // final_o is the count including the current beat, clamped at all-ones.
  always_comb begin
    w_sum   = {1'b0, cnt_q} + (CNT_W + 1)'($countones(keep_i));
    final_o = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (add_i) begin
      cnt_d = final_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/compressed_frame_parser.sv
// +------------------------------------------------------------------+
// | compressed_frame_parser: header -> meta channel, body pass-through|
// | Optional stats counters with COMP_PARSER_STATS_EN. Revision: 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

module compressed_frame_parser
  import compressed_frame_parser_pkg::*;
#(
  parameter int unsigned MAX_SIZE = PAGE_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI_DATA_BITS-1:0] axis_in_tdata_i,
  input  logic [KEEP_W-1:0]        axis_in_tkeep_i,
  input  logic                     axis_in_tlast_i,
  input  logic                     axis_in_tvalid_i,
  output logic                     axis_in_tready_o,
  output logic [AXI_DATA_BITS-1:0] axis_out_tdata_o,
  output logic [KEEP_W-1:0]        axis_out_tkeep_o,
  output logic                     axis_out_tlast_o,
  output logic [TID_W-1:0]         axis_out_tid_o,
  output logic                     axis_out_tvalid_o,
  input  logic                     axis_out_tready_i,
  output page_size_t               meta_uncom_size_o,
  output page_size_t               meta_com_size_o,
  output logic                     meta_valid_o,
  input  logic                     meta_ready_i,
  output logic                     err_hdr_o,
  output logic                     err_len_o
`ifdef COMP_PARSER_STATS_EN
  ,
  output logic [31:0]              stat_frames_o,
  output logic [31:0]              stat_bytes_in_o,
  output logic [31:0]              stat_err_hdr_o,
  output logic [31:0]              stat_err_len_o
`endif
);

  localparam int         SIZE_W = PAGE_SIZE_WIDTH;
  localparam page_size_t MAX_SZ = page_size_t'(MAX_SIZE);

  typedef enum logic [1:0] {HDR = 2'd0, BODY = 2'd1, DROP = 2'd2} parser_state_t;

  parser_state_t state_q;
  logic          run_q, meta_valid_q, err_hdr_q, err_len_q;
  page_size_t    uncom_q, com_q;

  frame_hdr_t      w_hdr;
  logic            w_in_hs, w_hdr_bad, w_hdr_err_ev, w_len_err_ev, w_body_last;
  logic [SIZE_W:0] w_final;

  assign w_hdr     = frame_hdr_t'(axis_in_tdata_i[HEADER_SIZE-1:0]);
  assign w_hdr_bad = axis_in_tlast_i || (w_hdr.com_size == '0) ||
                     (w_hdr.com_size > MAX_SZ) || (w_hdr.uncom_size > MAX_SZ);

  // run_q keeps tready low during reset and for the first edge after it.
  always_comb begin
    axis_in_tready_o  = 1'b0;
    axis_out_tvalid_o = 1'b0;
    case (state_q)
      HDR:  axis_in_tready_o = run_q && !meta_valid_q;
      BODY: begin
        axis_out_tvalid_o = axis_in_tvalid_i;
        axis_in_tready_o  = axis_out_tready_i;
      end
      DROP: axis_in_tready_o = 1'b1;
      default: axis_in_tready_o = 1'b0;
    endcase
  end

  assign w_in_hs      = axis_in_tvalid_i && axis_in_tready_o;
  assign w_body_last  = (state_q == BODY) && w_in_hs && axis_in_tlast_i;
  assign w_hdr_err_ev = (state_q == HDR) && w_in_hs && w_hdr_bad;
  assign w_len_err_ev = w_body_last && (w_final != {1'b0, com_q});

  assign axis_out_tdata_o  = axis_in_tdata_i;
  assign axis_out_tkeep_o  = axis_in_tkeep_i;
  assign axis_out_tlast_o  = axis_in_tlast_i;
  assign axis_out_tid_o    = '0;
  assign meta_uncom_size_o = uncom_q;
  assign meta_com_size_o   = com_q;
  assign meta_valid_o      = meta_valid_q;
  assign err_hdr_o         = err_hdr_q;
  assign err_len_o         = err_len_q;

  frame_byte_counter #(
    .KEEP_BITS (KEEP_W),
    .CNT_W     (SIZE_W + 1)
  ) u_byte_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i ((state_q == HDR) && w_in_hs),
    .add_i   ((state_q == BODY) && w_in_hs),
    .keep_i  (axis_in_tkeep_i),
    .final_o (w_final)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HDR;
      run_q        <= 1'b0;
      meta_valid_q <= 1'b0;
      uncom_q      <= '0;
      com_q        <= '0;
      err_hdr_q    <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      err_hdr_q <= w_hdr_err_ev;
      err_len_q <= w_len_err_ev;
      if (meta_valid_q && meta_ready_i) begin
        meta_valid_q <= 1'b0;
      end
      case (state_q)
        HDR: begin
          if (w_in_hs) begin
            uncom_q <= w_hdr.uncom_size;
            com_q   <= w_hdr.com_size;
            if (w_hdr_bad) begin
              state_q <= axis_in_tlast_i ? HDR : DROP;
            end else begin
              meta_valid_q <= 1'b1;
              state_q      <= BODY;
            end
          end
        end
        BODY: if (w_body_last) state_q <= HDR;
        DROP: if (w_in_hs && axis_in_tlast_i) state_q <= HDR;
        default: state_q <= HDR;
      endcase
    end
  end

`ifdef COMP_PARSER_STATS_EN
  logic [31:0] frames_q, bytes_q, err_hdr_cnt_q, err_len_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q      <= '0;
      bytes_q       <= '0;
      err_hdr_cnt_q <= '0;
      err_len_cnt_q <= '0;
    end else begin
      if (w_body_last) frames_q <= frames_q + 32'd1;
      if ((state_q == BODY) && w_in_hs) begin
        bytes_q <= bytes_q + 32'($countones(axis_in_tkeep_i));
      end
      if (w_hdr_err_ev) err_hdr_cnt_q <= err_hdr_cnt_q + 32'd1;
      if (w_len_err_ev) err_len_cnt_q <= err_len_cnt_q + 32'd1;
    end
  end

  assign stat_frames_o   = frames_q;
  assign stat_bytes_in_o = bytes_q;
  assign stat_err_hdr_o  = err_hdr_cnt_q;
  assign stat_err_len_o  = err_len_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_compressed_frame_parser.sv
// Randomized self-checking bench for compressed_frame_parser with a frame-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_compressed_frame_parser;
  import compressed_frame_parser_pkg::*;

  localparam int DW = AXI_DATA_BITS;
  localparam int KW = KEEP_W;
  localparam int CW = DW + KW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]    in_tdata = '0;
  logic [KW-1:0]    in_tkeep = '0;
  logic             in_tlast = 1'b0, in_tvalid = 1'b0, in_tready;
  logic [DW-1:0]    out_tdata;
  logic [KW-1:0]    out_tkeep;
  logic             out_tlast, out_tvalid;
  logic             out_tready = 1'b1;
  logic [TID_W-1:0] out_tid;
  page_size_t       meta_uncom, meta_com;
  logic             meta_valid, meta_ready = 1'b1, err_hdr, err_len;

  compressed_frame_parser dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .axis_in_tdata_i   (in_tdata),
    .axis_in_tkeep_i   (in_tkeep),
    .axis_in_tlast_i   (in_tlast),
    .axis_in_tvalid_i  (in_tvalid),
    .axis_in_tready_o  (in_tready),
    .axis_out_tdata_o  (out_tdata),
    .axis_out_tkeep_o  (out_tkeep),
    .axis_out_tlast_o  (out_tlast),
    .axis_out_tid_o    (out_tid),
    .axis_out_tvalid_o (out_tvalid),
    .axis_out_tready_i (out_tready),
    .meta_uncom_size_o (meta_uncom),
    .meta_com_size_o   (meta_com),
    .meta_valid_o      (meta_valid),
    .meta_ready_i      (meta_ready),
    .err_hdr_o         (err_hdr),
    .err_len_o         (err_len)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: where the next input beat belongs, pending meta words, pending error pulses.
  bit         m_expect_hdr = 1'b1;
  bit         m_dropping   = 1'b0;
  int         m_bytes      = 0;
  int         m_com        = 0;
  bit         exp_err_hdr  = 1'b0;
  bit         exp_err_len  = 1'b0;
  page_size_t q_uncom[$];
  page_size_t q_com[$];
  bit         seen_edge;

  bit rand_out  = 1'b0;
  bit rand_meta = 1'b0;
  bit use_gaps  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_edge <= 1'b0;
    else        seen_edge <= 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (rand_out)  out_tready = ($urandom_range(0, 3) != 0);
    if (rand_meta) meta_ready = ($urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    int uncom_v, com_v;
    if (!rst_n) begin
      check_eq("rst_in_tready", in_tready, 0);
      check_eq("rst_out_tvalid", out_tvalid, 0);
      check_eq("rst_meta_valid", meta_valid, 0);
      check_eq("rst_meta_sizes", {meta_uncom, meta_com}, 0);
      check_eq("rst_errs", {err_hdr, err_len}, 0);
      m_expect_hdr = 1'b1;
      m_dropping   = 1'b0;
      exp_err_hdr  = 1'b0;
      exp_err_len  = 1'b0;
      q_uncom.delete();
      q_com.delete();
    end else begin
      check_eq("err_hdr", err_hdr, exp_err_hdr);
      check_eq("err_len", err_len, exp_err_len);
      check_eq("meta_valid", meta_valid, q_com.size() != 0);
      if (m_expect_hdr) begin
        if (seen_edge) check_eq("hdr_tready", in_tready, q_com.size() == 0);
        check_eq("hdr_out_tvalid", out_tvalid, 0);
      end else if (m_dropping) begin
        check_eq("drop_tready", in_tready, 1);
        check_eq("drop_out_tvalid", out_tvalid, 0);
      end else begin
        check_eq("body_out_tvalid", out_tvalid, in_tvalid);
        check_eq("body_in_tready", in_tready, out_tready);
        if (in_tvalid) begin
          check_eq("body_tdata", out_tdata, in_tdata);
          check_eq("body_tkeep", out_tkeep, in_tkeep);
          check_eq("body_tlast", out_tlast, in_tlast);
          check_eq("body_tid", out_tid, 0);
        end
      end
      exp_err_hdr = 1'b0;
      exp_err_len = 1'b0;
      if (meta_valid && meta_ready && q_com.size() != 0) begin
        check_eq("meta_uncom", meta_uncom, q_uncom[0]);
        check_eq("meta_com", meta_com, q_com[0]);
        void'(q_uncom.pop_front());
        void'(q_com.pop_front());
      end
      if (in_tvalid && in_tready) begin
        if (m_expect_hdr) begin
          com_v   = int'(in_tdata[15:0]);
          uncom_v = int'(in_tdata[31:16]);
          if (!in_tlast && com_v != 0 && com_v <= PAGE_SIZE && uncom_v <= PAGE_SIZE) begin
            q_uncom.push_back(page_size_t'(uncom_v));
            q_com.push_back(page_size_t'(com_v));
            m_com        = com_v;
            m_bytes      = 0;
            m_expect_hdr = 1'b0;
          end else begin
            exp_err_hdr = 1'b1;
            if (!in_tlast) begin
              m_dropping   = 1'b1;
              m_expect_hdr = 1'b0;
            end
          end
        end else if (m_dropping) begin
          if (in_tlast) begin
            m_dropping   = 1'b0;
            m_expect_hdr = 1'b1;
          end
        end else begin
          m_bytes += $countones(in_tkeep);
          if (in_tlast) begin
            exp_err_len  = (m_bytes != m_com);
            m_expect_hdr = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [KW-1:0] mask_n(input int n);
    logic [KW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit l);
    int t;
    t = 0;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    in_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_tready) break;
      t++;
      if (t > 500) begin
        check_eq("handshake_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
    if (use_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input int uncom, input int com, input int nbody,
                            input logic [KW-1:0] last_keep, input bit hdr_last);
    logic [DW-1:0] d;
    d = rand_data();
    d[31:0] = {uncom[15:0], com[15:0]};
    send_beat(d, '1, hdr_last);
    if (!hdr_last) begin
      for (int i = 0; i < nbody; i++) begin
        send_beat(rand_data(), (i == nbody - 1) ? last_keep : '1, i == nbody - 1);
      end
    end
  endtask

  int            kind, nb, bytes;
  logic [KW-1:0] kl;

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_frame(4096, 100, 2, mask_n(36), 0);
    send_frame(4096, 120, 2, mask_n(36), 0);
    send_frame(4096, 0, 3, '1, 0);
    send_frame(2000, 64, 1, '1, 0);

    meta_ready = 1'b0;
    fork
      begin
        send_frame(100, 64, 1, '1, 0);
        send_frame(200, 128, 2, '1, 0);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        meta_ready = 1'b1;
      end
    join

    rand_out  = 1'b1;
    rand_meta = 1'b1;
    use_gaps  = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind  = $urandom_range(0, 9);
      nb    = $urandom_range(1, 8);
      kl    = {$urandom, $urandom};
      bytes = 64 * (nb - 1) + $countones(kl);
      case (kind)
        0:       send_frame(4096, 0, nb, kl, 0);
        1:       send_frame(4097 + $urandom_range(0, 100), bytes, nb, kl, 0);
        2:       send_frame(100, 4097 + $urandom_range(0, 100), nb, kl, 0);
        3:       send_frame(100, 64, 0, '1, 1);
        4, 5:    send_frame($urandom_range(0, 4096), bytes + 1, nb, kl, 0);
        default: send_frame($urandom_range(0, 4096), bytes, nb, kl, 0);
      endcase
    end
    rand_out  = 1'b0;
    rand_meta = 1'b0;
    use_gaps  = 1'b0;
    #1;
    out_tready = 1'b1;
    meta_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send_beat({rand_data()} & ~{{(DW-32){1'b0}}, 32'hFFFF_FFFF} | {{(DW-32){1'b0}}, 32'h0100_0100}, '1, 0);
    send_beat(rand_data(), '1, 0);
    in_tdata  = rand_data();
    in_tkeep  = '1;
    in_tlast  = 1'b0;
    in_tvalid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_tvalid", out_tvalid, 0);
    check_eq("async_rst_in_tready", in_tready, 0);
    check_eq("async_rst_meta_valid", meta_valid, 0);
    in_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(300, 200, 4, mask_n(8), 0);
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
